// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing controller for a 5-stage (IF/ID/EX/MEM/WB) core.
// Keeps a shadow copy of destination info for EX, MEM and WB. It produces the registered
// forwarding selects for EX, the stall/bubble/flush controls for load-use and RAW hazards and
// taken branches, and freezes the pipe on memory busy or HALT.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   id_*                decoded info for the instruction currently in ID
//   branch_cond         taken branch/jump resolved in EX
//   mem_busy            memory not ready; the whole pipe holds
//   forwardA/forwardB   registered ALU operand selects: 00 reg, 01 WB data, 10 EX/MEM ALU out
//   stall_fd            hold PC and IF/ID
//   bubble_ex           load a NOP into ID/EX
//   flush_fd            squash IF/ID
//   freeze              all pipeline registers hold
//   halted              core halted (cleared only by reset)
module hazard_ctrl #(
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned REG_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_sel,
  input  logic             id_mem_rd,
  input  logic             id_halt,
  input  logic             branch_cond,
  input  logic             mem_busy,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             stall_fd,
  output logic             bubble_ex,
  output logic             flush_fd,
  output logic             freeze,
  output logic             halted
);

  typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_e;

  typedef struct packed {
    logic             valid;
    logic             wr_en;
    logic [REG_W-1:0] wr_sel;
    logic             mem_rd;
    logic             halt;
  } shadow_t;

  state_e     state_q, state_d;
  shadow_t    ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic halt_hit, raw_stall;

  // Source/producer matches for the instruction in ID.
  always_comb begin
    ex_hit_a  = ex_q.valid  & ex_q.wr_en  & id_rs_used & (ex_q.wr_sel  == id_rs);
    ex_hit_b  = ex_q.valid  & ex_q.wr_en  & id_rt_used & (ex_q.wr_sel  == id_rt);
    mem_hit_a = mem_q.valid & mem_q.wr_en & id_rs_used & (mem_q.wr_sel == id_rs);
    mem_hit_b = mem_q.valid & mem_q.wr_en & id_rt_used & (mem_q.wr_sel == id_rt);
  end

  always_comb begin
    halt_hit = wb_q.valid & wb_q.halt;
    if (FWD_EN) begin
      // Only a load in EX cannot be forwarded in time.
      raw_stall = id_valid & ex_q.mem_rd & (ex_hit_a | ex_hit_b);
    end else begin
      raw_stall = id_valid & (ex_hit_a | ex_hit_b | mem_hit_a | mem_hit_b);
    end
  end

  // Combinational pipeline controls: freeze beats branch flush beats hazard stall.
  always_comb begin
    halted    = (state_q == StHalt) | halt_hit;
    freeze    = halted | mem_busy;
    stall_fd  = 1'b0;
    bubble_ex = 1'b0;
    flush_fd  = 1'b0;
    if (!freeze) begin
      if (branch_cond) begin
        // Squash both younger instructions; any pending stall is moot.
        flush_fd  = 1'b1;
        bubble_ex = 1'b1;
      end else if (raw_stall) begin
        stall_fd  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

  // Shadow pipe and forwarding selects advance together with the real pipe.
  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (!freeze) begin
      wb_d    = mem_q;
      mem_d   = ex_q;
      ex_d    = '0;
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
      if (id_valid && !bubble_ex) begin
        ex_d.valid  = 1'b1;
        ex_d.wr_en  = id_wr_en;
        ex_d.wr_sel = id_wr_sel;
        ex_d.mem_rd = id_mem_rd;
        ex_d.halt   = id_halt;
        // WB producers are covered by the register-file write-before-read bypass.
        if (FWD_EN) begin
          if (ex_hit_a)       fwd_a_d = 2'b10;
          else if (mem_hit_a) fwd_a_d = 2'b01;
          if (ex_hit_b)       fwd_b_d = 2'b10;
          else if (mem_hit_b) fwd_b_d = 2'b01;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun, StMemWait: begin
        if (halt_hit)      state_d = StHalt;
        else if (mem_busy) state_d = StMemWait;
        else               state_d = StRun;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign forwardA = fwd_a_q;
  assign forwardB = fwd_b_q;

endmodule
